ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit. Owns the architectural PC register and consumes the next-PC result (pc_in, pc_w_en) produced by the execute-stage PC logic.
- Issues one instruction-memory read per instruction over a valid/ready request channel and a valid response channel.
- Presents the fetched word to decode and holds it until execute commits the next PC.
- Strictly one instruction in flight; no prefetch, no branch prediction.

Parameters:
- ISA_WIDTH, 32, width of the PC, the memory address and the instruction word.
- RESET_PC, 32'h8000_0000, PC value loaded by reset.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_in  input  ISA_WIDTH  next PC from execute.
- pc_w_en  input  1  execute commits pc_in; honoured only in EXEC.
- pc_out  output  ISA_WIDTH  current PC register, registered.
- imem_req_valid  output  1  read request valid; equals (state==REQ).
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  ISA_WIDTH  equals pc_out.
- imem_rsp_valid  input  1  read data valid; honoured only in WAIT.
- imem_rsp_data  input  ISA_WIDTH  instruction word.
- imem_rsp_err  input  1  access fault; qualified by imem_rsp_valid.
- inst  output  ISA_WIDTH  latched instruction, registered.
- inst_valid  output  1  equals (state==EXEC).
- fault  output  1  sticky fault flag, registered.
- retire_cnt  output  CNT_WIDTH  count of committed instructions.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE, pc_out=RESET_PC, inst=0, fault=0, retire_cnt=0.
  - Hence imem_req_valid=0 and inst_valid=0.
- States are IDLE, REQ, WAIT, EXEC, FAULT. Transitions:
  - IDLE -> REQ unconditionally on the first clock edge after rst deasserts.
  - REQ: imem_req_valid=1 and imem_req_addr=pc_out, both held stable until the handshake. On imem_req_valid & imem_req_ready, go to WAIT.
  - WAIT: no request is issued. On imem_rsp_valid with imem_rsp_err=0: inst <= imem_rsp_data, go to EXEC. On imem_rsp_valid with imem_rsp_err=1: fault <= 1, go to FAULT; inst is unchanged.
    - A response arriving in the same cycle as the request handshake is not legal for the memory and is ignored here.
  - EXEC: inst_valid=1 and inst is held stable. On pc_w_en:
    - pc_out <= pc_in and retire_cnt <= retire_cnt+1 (the counter wraps to 0 at its maximum).
    - If pc_in[1:0]==2'b00, go to REQ; otherwise fault <= 1 and go to FAULT. In the fault case the PC is still updated, so pc_out shows the offending address.
  - FAULT: terminal state until rst. All outputs are held, imem_req_valid=0, inst_valid=0.
- Ignored inputs:
  - pc_w_en outside EXEC: no effect on pc_out or retire_cnt.
  - imem_rsp_valid outside WAIT: no effect on any state.
- Latency:
  - pc_w_en at edge N: the new pc_out and imem_req_valid are visible after edge N.
  - With ready=1 and a one-cycle response, the minimum loop is REQ -> WAIT -> EXEC, i.e. 3 cycles per instruction.
- Reset mid-operation: any state returns immediately to the reset values. An outstanding memory response after reset falls in IDLE or REQ and is therefore ignored.
- Simultaneous events need no arbitration, because every input is qualified by exactly one state.

Test Plan:
- Reset release: pc_out=0x80000000, imem_req_valid=0 during reset; one cycle after release, imem_req_valid=1 and imem_req_addr=0x80000000.
- Normal fetch, ready=1, response 0x00500093 one cycle later -> inst=0x00500093, inst_valid=1. Then pc_w_en=1 with pc_in=0x80000004 -> pc_out=0x80000004, retire_cnt=1, new request issued.
- Backpressure: imem_req_ready=0 for 5 cycles -> imem_req_valid and imem_req_addr held constant. A spurious imem_rsp_valid during REQ -> inst unchanged.
- Stall in EXEC: pc_w_en held 0 for 10 cycles -> inst_valid=1, inst unchanged, retire_cnt unchanged. A pc_w_en pulse during WAIT -> pc_out unchanged.
- Faults, two cases:
  - imem_rsp_err=1 -> fault=1, state FAULT, no further requests issued.
  - Separately, pc_w_en with pc_in=0x80000102 -> pc_out=0x80000102, fault=1, imem_req_valid stays 0.
- Async reset asserted in WAIT between clock edges -> outputs return to reset values immediately, without waiting for clk; a late response after release is ignored.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with one instruction in flight.
//   Holds the architectural PC, issues one read per instruction over a
//   valid/ready request channel, and latches the returned word for decode.
//   The word is held until execute commits the next PC.
//
// Ports:
//   clk, rst        clock (rising edge) / asynchronous active-high reset
//   pc_in, pc_w_en  next PC from execute; honoured only in EXEC
//   pc_out          current PC register
//   imem_req_*      read request channel (valid/ready, addr = pc_out)
//   imem_rsp_*      read response channel (valid, data, err); honoured only in WAIT
//   inst            latched instruction word
//   inst_valid      high while in EXEC
//   fault           sticky fault flag (access fault or misaligned next PC)
//   retire_cnt      number of committed instructions (wraps)
module ifu_fetch #(
    parameter int unsigned              ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0]     RESET_PC  = 32'h8000_0000,
    parameter int unsigned              CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ISA_WIDTH-1:0]  pc_in,
    input  logic                  pc_w_en,
    output logic [ISA_WIDTH-1:0]  pc_out,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ISA_WIDTH-1:0]  imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [ISA_WIDTH-1:0]  imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic [ISA_WIDTH-1:0]  inst,
    output logic                  inst_valid,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_FAULT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [ISA_WIDTH-1:0]   pc_q;
    logic [ISA_WIDTH-1:0]   inst_q;
    logic                   fault_q;
    logic [CNT_WIDTH-1:0]   retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            fault_q      <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    // Responses are not accepted here: a response in the
                    // handshake cycle is illegal for the memory.
                    if (imem_req_ready) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end else begin
                            inst_q  <= imem_rsp_data;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (pc_w_en) begin
                        // PC updates even when misaligned so the offending
                        // address remains visible after the fault.
                        pc_q         <= pc_in;
                        retire_cnt_q <= retire_cnt_q + CNT_ONE;
                        if (pc_in[1:0] == 2'b00) begin
                            state_q <= S_REQ;
                        end else begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end
                    end
                end
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc_out         = pc_q;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = (state_q == S_REQ);
    assign inst_valid     = (state_q == S_EXEC);
    assign inst           = inst_q;
    assign fault          = fault_q;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_w_en;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ifu_fetch #(
        .ISA_WIDTH (32),
        .RESET_PC  (32'h8000_0000),
        .CNT_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_w_en        (pc_w_en),
        .pc_out         (pc_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .fault          (fault),
        .retire_cnt     (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pc_out"},     pc_out,         64'h8000_0000);
        chk({tag, " req_valid"},  imem_req_valid, 64'h0);
        chk({tag, " inst_valid"}, inst_valid,     64'h0);
        chk({tag, " inst"},       inst,           64'h0);
        chk({tag, " fault"},      fault,          64'h0);
        chk({tag, " retire"},     retire_cnt,     64'h0);
    endtask

    initial begin
        rst            = 1'b1;
        pc_in          = '0;
        pc_w_en        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;

        // Reset state (after the edge at t=5, rst still high)
        #7;
        chk_reset_vals("reset");
        #5 rst = 1'b0;                       // t=12
        tick();                              // IDLE -> REQ
        chk("rel req_valid", imem_req_valid, 64'h1);
        chk("rel req_addr",  imem_req_addr,  64'h8000_0000);

        // Backpressure with a spurious response during REQ
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp req_valid", imem_req_valid, 64'h1);
            chk("bp req_addr",  imem_req_addr,  64'h8000_0000);
            chk("bp inst",      inst,           64'h0);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();                              // REQ -> WAIT
        chk("wait req_valid",  imem_req_valid, 64'h0);
        chk("wait inst_valid", inst_valid,     64'h0);

        // pc_w_en during WAIT is ignored; response arrives
        imem_req_ready = 1'b0;
        pc_w_en        = 1'b1;
        pc_in          = 32'h1234_5678;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        tick();                              // WAIT -> EXEC
        chk("exec inst",       inst,       64'h0050_0093);
        chk("exec inst_valid", inst_valid, 64'h1);
        chk("wait pc_w_en pc", pc_out,     64'h8000_0000);
        chk("wait pc_w_en cnt", retire_cnt, 64'h0);
        pc_w_en        = 1'b0;
        imem_rsp_valid = 1'b0;

        // Stall in EXEC, stray response ignored
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall inst_valid", inst_valid, 64'h1);
            chk("stall inst",       inst,       64'h0050_0093);
            chk("stall retire",     retire_cnt, 64'h0);
        end
        imem_rsp_valid = 1'b0;

        // Commit next PC
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0004;
        tick();                              // EXEC -> REQ
        pc_w_en = 1'b0;
        chk("commit pc",         pc_out,         64'h8000_0004);
        chk("commit retire",     retire_cnt,     64'h1);
        chk("commit req_valid",  imem_req_valid, 64'h1);
        chk("commit req_addr",   imem_req_addr,  64'h8000_0004);
        chk("commit inst_valid", inst_valid,     64'h0);
        chk("commit fault",      fault,          64'h0);

        // Minimum 3-cycle loop, then misaligned next PC
        imem_req_ready = 1'b1;
        tick();                              // REQ -> WAIT
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0113;
        tick();                              // WAIT -> EXEC
        imem_rsp_valid = 1'b0;
        chk("loop2 inst",       inst,       64'h00A0_0113);
        chk("loop2 inst_valid", inst_valid, 64'h1);
        pc_w_en = 1'b1;
        pc_in   = 32'h8000_0102;
        tick();                              // EXEC -> FAULT
        pc_w_en = 1'b0;
        chk("mis pc",         pc_out,         64'h8000_0102);
        chk("mis fault",      fault,          64'h1);
        chk("mis retire",     retire_cnt,     64'h2);
        chk("mis req_valid",  imem_req_valid, 64'h0);
        chk("mis inst_valid", inst_valid,     64'h0);

        // FAULT is terminal: every input ignored
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_5555;
        pc_w_en        = 1'b1;
        pc_in          = 32'h9000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fault req_valid", imem_req_valid, 64'h0);
            chk("fault pc",        pc_out,         64'h8000_0102);
            chk("fault inst",      inst,           64'h00A0_0113);
            chk("fault retire",    retire_cnt,     64'h2);
            chk("fault flag",      fault,          64'h1);
        end
        pc_w_en        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;

        // Async reset out of FAULT, between edges
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst1");
        @(negedge clk);
        rst = 1'b0;
        tick();                              // IDLE -> REQ
        imem_req_ready = 1'b1;
        tick();                              // REQ -> WAIT
        imem_req_ready = 1'b0;
        chk("rst2 pre req_valid", imem_req_valid, 64'h0);

        // Async reset in WAIT; late response after release ignored
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst2");
        @(negedge clk);
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0BAD;
        tick();                              // IDLE -> REQ
        chk("late inst",       inst,           64'h0);
        chk("late inst_valid", inst_valid,     64'h0);
        chk("late req_valid",  imem_req_valid, 64'h1);
        tick();                              // still REQ (ready=0)
        chk("late2 inst",      inst,           64'h0);
        chk("late2 req_valid", imem_req_valid, 64'h1);
        imem_rsp_valid = 1'b0;

        // Access fault on response
        imem_req_ready = 1'b1;
        tick();                              // REQ -> WAIT
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        tick();                              // WAIT -> FAULT
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        chk("err fault",      fault,          64'h1);
        chk("err inst",       inst,           64'h0);
        chk("err inst_valid", inst_valid,     64'h0);
        chk("err req_valid",  imem_req_valid, 64'h0);
        chk("err pc",         pc_out,         64'h8000_0000);
        imem_req_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("err hold req_valid", imem_req_valid, 64'h0);
            chk("err hold fault",     fault,          64'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
